// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the two-mode minutes:seconds counter.
package timer_pkg;

   localparam int W       = 8;
   localparam int MAX_MSB = 99;
   localparam int MAX_LSB = 59;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with load; wrap flags the carry (up) or borrow (down).
module mod_updown_counter #(
   parameter int MOD = 60,
   parameter int W   = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         up,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         wrap
);

   localparam logic [W-1:0] TOP = W'(MOD - 1);

   logic [W-1:0] q_d;

   always_comb begin
      wrap = en && (up ? (q == TOP) : (q == '0));
   end

   always_comb begin
      q_d = q;
      if (ld) begin
         q_d = d;
      end else if (en) begin
         if (up) q_d = wrap ? '0 : q + W'(1);
         else    q_d = wrap ? TOP : q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) q <= '0;
      else        q <= q_d;
   end

endmodule

// File: rtl/two_mode_time_counter.sv
// Minutes:seconds time source: mode A counts up from 00:00, mode B counts down from a preset.
//
// state      | meaning
// ST_IDLE    | value held, ModeActive follows ModeSel, presets may be loaded
// ST_RUNNING | counting one second per edge in the latched mode
// ST_PAUSED  | value frozen, presets may be loaded, Start resumes
// ST_DONE    | terminal value reached and held; only Clear or Load leave
module two_mode_time_counter
   import timer_pkg::*;
#(
   parameter int W       = timer_pkg::W,
   parameter int MAX_MSB = timer_pkg::MAX_MSB,
   parameter int MAX_LSB = timer_pkg::MAX_LSB
) (
   input  logic         CLK_1Hz,
   input  logic         Reset_n,
   input  logic         ModeSel,
   input  logic         Start,
   input  logic         Pause,
   input  logic         Clear,
   input  logic         Load,
   input  logic [W-1:0] PresetMSB,
   input  logic [W-1:0] PresetLSB,
   output logic [W-1:0] MSB,
   output logic [W-1:0] LSB,
   output logic         Stopped,
   output logic         ModeActive,
   output logic         Done
);

   localparam logic [W-1:0] MSB_TOP = W'(MAX_MSB);
   localparam logic [W-1:0] LSB_TOP = W'(MAX_LSB);

   state_e       state_q, state_d;
   logic         mode_q, mode_d;
   logic         stopped_q, done_q;
   logic [W-1:0] msb_q, lsb_q;
   logic [W-1:0] ld_msb, ld_lsb;
   logic         cnt_en, cnt_ld;
   logic         sec_wrap, min_wrap_unused;
   logic         at_term, next_term;

   // at_term stops an already-terminal start without moving; next_term flags the final count edge
   always_comb begin
      at_term   = mode_q ? (msb_q == '0 && lsb_q == '0)
                         : (msb_q == MSB_TOP && lsb_q == LSB_TOP);
      next_term = mode_q ? (msb_q == '0 && lsb_q == W'(1))
                         : (msb_q == MSB_TOP && lsb_q == LSB_TOP - W'(1));
   end

   always_comb begin
      cnt_ld = Clear || (Load && state_q != ST_RUNNING);
      ld_msb = '0;
      ld_lsb = '0;
      if (!Clear) begin
         ld_msb = (PresetMSB > MSB_TOP) ? MSB_TOP : PresetMSB;
         ld_lsb = (PresetLSB > LSB_TOP) ? LSB_TOP : PresetLSB;
      end
      cnt_en = !Clear && state_q == ST_RUNNING && !Pause && !at_term;
   end

   always_comb begin
      state_d = state_q;
      if (Clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_PAUSED: if (!Load && !Pause && Start) state_d = ST_RUNNING;
            ST_RUNNING: begin
               if (Pause)                     state_d = ST_PAUSED;
               else if (at_term || next_term) state_d = ST_DONE;
            end
            ST_DONE:    if (Load) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
      mode_d = (Clear || state_q == ST_IDLE) ? ModeSel : mode_q;
   end

   always_ff @(posedge CLK_1Hz) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= 1'b0;
         stopped_q <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         stopped_q <= (state_d != ST_RUNNING);
         done_q    <= (state_d == ST_DONE) && (state_q != ST_DONE);
      end
   end

   mod_updown_counter #(.MOD(MAX_LSB + 1), .W(W)) u_sec (
      .clk   (CLK_1Hz),
      .rst_n (Reset_n),
      .en    (cnt_en),
      .up    (!mode_q),
      .ld    (cnt_ld),
      .d     (ld_lsb),
      .q     (lsb_q),
      .wrap  (sec_wrap)
   );

   mod_updown_counter #(.MOD(MAX_MSB + 1), .W(W)) u_min (
      .clk   (CLK_1Hz),
      .rst_n (Reset_n),
      .en    (sec_wrap),
      .up    (!mode_q),
      .ld    (cnt_ld),
      .d     (ld_msb),
      .q     (msb_q),
      .wrap  (min_wrap_unused)
   );

   assign MSB        = msb_q;
   assign LSB        = lsb_q;
   assign Stopped    = stopped_q;
   assign ModeActive = mode_q;
   assign Done       = done_q;

endmodule

// File: tb/tb_two_mode_time_counter.sv
// Bench for two_mode_time_counter: directed vector table, a full mode-B countdown, then random stimulus vs a seconds-based model.
module tb_two_mode_time_counter;

   logic       CLK_1Hz = 1'b0;
   logic       Reset_n, ModeSel, Start, Pause, Clear, Load;
   logic [7:0] PresetMSB, PresetLSB;
   logic [7:0] MSB, LSB;
   logic       Stopped, ModeActive, Done;

   two_mode_time_counter dut (
      .CLK_1Hz    (CLK_1Hz),
      .Reset_n    (Reset_n),
      .ModeSel    (ModeSel),
      .Start      (Start),
      .Pause      (Pause),
      .Clear      (Clear),
      .Load       (Load),
      .PresetMSB  (PresetMSB),
      .PresetLSB  (PresetLSB),
      .MSB        (MSB),
      .LSB        (LSB),
      .Stopped    (Stopped),
      .ModeActive (ModeActive),
      .Done       (Done)
   );

   always #5 CLK_1Hz = ~CLK_1Hz;

   typedef struct {
      string name;
      bit    rst_n, clr, ld, pause, start, msel;
      int    pm, pl;
      int    e_msb, e_lsb;
      bit    e_stop, e_mode, e_done;
   } vec_t;

   vec_t tbl[$];
   int   vectors    = 0;
   int   miscompares = 0;

   // Reference model: the value is a single count of seconds; minutes/seconds are derived from it.
   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_e;
   localparam int TMAX = 99 * 60 + 59;
   mst_e m_st   = M_IDLE;
   int   m_t    = 0;
   bit   m_mode = 1'b0;
   bit   m_done = 1'b0;

   function automatic int preset_secs();
      int mn, sc;
      mn = (int'(PresetMSB) > 99) ? 99 : int'(PresetMSB);
      sc = (int'(PresetLSB) > 59) ? 59 : int'(PresetLSB);
      return mn * 60 + sc;
   endfunction

   task automatic model_step();
      if (!Reset_n) begin
         m_t = 0; m_st = M_IDLE; m_mode = 1'b0; m_done = 1'b0;
         return;
      end
      m_done = 1'b0;
      if (Clear) begin
         m_t = 0; m_st = M_IDLE; m_mode = ModeSel;
      end else begin
         case (m_st)
            M_IDLE: begin
               m_mode = ModeSel;
               if (Load) m_t = preset_secs();
               else if (!Pause && Start) m_st = M_RUN;
            end
            M_RUN: begin
               if (Pause) m_st = M_PAUSE;
               else begin
                  if (m_mode ? (m_t > 0) : (m_t < TMAX)) m_t = m_mode ? m_t - 1 : m_t + 1;
                  if (m_mode ? (m_t == 0) : (m_t == TMAX)) begin
                     m_st = M_DONE; m_done = 1'b1;
                  end
               end
            end
            M_PAUSE: begin
               if (Load) m_t = preset_secs();
               else if (!Pause && Start) m_st = M_RUN;
            end
            M_DONE: begin
               if (Load) begin m_t = preset_secs(); m_st = M_IDLE; end
            end
            default: m_st = M_IDLE;
         endcase
      end
   endtask

   function automatic void add(string n, bit r, bit c, bit l, bit p, bit s, bit m,
                               int pm, int pl, int em, int el, bit es, bit emo, bit ed);
      vec_t v;
      v.name = n; v.rst_n = r; v.clr = c; v.ld = l; v.pause = p; v.start = s; v.msel = m;
      v.pm = pm; v.pl = pl; v.e_msb = em; v.e_lsb = el;
      v.e_stop = es; v.e_mode = emo; v.e_done = ed;
      tbl.push_back(v);
   endfunction

   task automatic drive(bit r, bit c, bit l, bit p, bit s, bit m, int pm, int pl);
      Reset_n = r; Clear = c; Load = l; Pause = p; Start = s; ModeSel = m;
      PresetMSB = 8'(pm); PresetLSB = 8'(pl);
   endtask

   task automatic tick();
      @(posedge CLK_1Hz);
      model_step();
      @(negedge CLK_1Hz);
   endtask

   task automatic check(string n, int em, int el, bit es, bit emo, bit ed);
      vectors++;
      if (MSB !== 8'(em) || LSB !== 8'(el) || Stopped !== es || ModeActive !== emo || Done !== ed) begin
         miscompares++;
         $display("FAIL %s: got %0d:%0d stopped=%0b mode=%0b done=%0b, expected %0d:%0d stopped=%0b mode=%0b done=%0b",
                  n, MSB, LSB, Stopped, ModeActive, Done, em, el, es, emo, ed);
      end
   endtask

   initial begin
      int t;
      //   name            rst clr ld pa st ms  pm  pl   msb lsb st mo dn
      add("reset0",         0, 0, 0, 0, 0, 0,   0,  0,   0,  0, 1, 0, 0);
      add("reset1",         0, 0, 0, 0, 1, 1,   0,  0,   0,  0, 1, 0, 0);
      add("release",        1, 0, 0, 0, 0, 0,   0,  0,   0,  0, 1, 0, 0);
      add("a_load58",       1, 0, 1, 0, 0, 0,   0, 58,   0, 58, 1, 0, 0);
      add("a_start",        1, 0, 0, 0, 1, 0,   0,  0,   0, 58, 0, 0, 0);
      add("a_cnt59",        1, 0, 0, 0, 0, 0,   0,  0,   0, 59, 0, 0, 0);
      add("a_roll",         1, 0, 0, 0, 0, 0,   0,  0,   1,  0, 0, 0, 0);
      add("a_cnt101",       1, 0, 0, 0, 0, 0,   0,  0,   1,  1, 0, 0, 0);
      add("clear1",         1, 1, 0, 0, 0, 0,   0,  0,   0,  0, 1, 0, 0);
      add("clamp",          1, 0, 1, 0, 0, 0, 150, 75,  99, 59, 1, 0, 0);
      add("max_start",      1, 0, 0, 0, 1, 0,   0,  0,  99, 59, 0, 0, 0);
      add("max_done",       1, 0, 0, 0, 0, 0,   0,  0,  99, 59, 1, 0, 1);
      add("done_hold",      1, 0, 0, 0, 0, 0,   0,  0,  99, 59, 1, 0, 0);
      add("done_nostart",   1, 0, 0, 0, 1, 0,   0,  0,  99, 59, 1, 0, 0);
      add("done_load",      1, 0, 1, 0, 0, 0,   0,  9,   0,  9, 1, 0, 0);
      add("p_start",        1, 0, 0, 0, 1, 0,   0,  0,   0,  9, 0, 0, 0);
      add("p_cnt10",        1, 0, 0, 0, 0, 0,   0,  0,   0, 10, 0, 0, 0);
      add("p_pause",        1, 0, 0, 1, 0, 0,   0,  0,   0, 10, 1, 0, 0);
      add("p_modesel",      1, 0, 0, 1, 0, 1,   0,  0,   0, 10, 1, 0, 0);
      add("p_modesel2",     1, 0, 0, 0, 0, 1,   0,  0,   0, 10, 1, 0, 0);
      add("p_resume",       1, 0, 0, 0, 1, 1,   0,  0,   0, 10, 0, 0, 0);
      add("p_cnt11",        1, 0, 0, 0, 0, 1,   0,  0,   0, 11, 0, 0, 0);
      add("run_load_ign",   1, 0, 1, 0, 0, 1,   0, 40,   0, 12, 0, 0, 0);
      add("run_st_pa",      1, 0, 0, 1, 1, 1,   0,  0,   0, 12, 1, 0, 0);
      add("pause_load",     1, 0, 1, 0, 0, 1,   0,  5,   0,  5, 1, 0, 0);
      add("clear_mode",     1, 1, 0, 0, 0, 1,   0,  0,   0,  0, 1, 1, 0);
      add("idle_st_pa",     1, 0, 0, 1, 1, 1,   0,  0,   0,  0, 1, 1, 0);
      add("b_zero_start",   1, 0, 0, 0, 1, 1,   0,  0,   0,  0, 0, 1, 0);
      add("b_zero_done",    1, 0, 0, 0, 0, 1,   0,  0,   0,  0, 1, 1, 1);
      add("clear_a",        1, 1, 0, 0, 0, 0,   0,  0,   0,  0, 1, 0, 0);
      add("b_load31",       1, 0, 1, 0, 0, 1,   0, 31,   0, 31, 1, 1, 0);
      add("b_start",        1, 0, 0, 0, 1, 1,   0,  0,   0, 31, 0, 1, 0);
      add("b_cnt30",        1, 0, 0, 0, 0, 0,   0,  0,   0, 30, 0, 1, 0);
      add("b_clear",        1, 1, 0, 0, 0, 0,   0,  0,   0,  0, 1, 0, 0);
      add("b_load31b",      1, 0, 1, 0, 0, 1,   0, 31,   0, 31, 1, 1, 0);
      add("b_start2",       1, 0, 0, 0, 1, 1,   0,  0,   0, 31, 0, 1, 0);
      add("b_cnt30b",       1, 0, 0, 0, 0, 1,   0,  0,   0, 30, 0, 1, 0);
      add("b_reset",        0, 0, 0, 0, 1, 1,   0,  0,   0,  0, 1, 0, 0);
      add("b_release",      1, 0, 0, 0, 0, 1,   0,  0,   0,  0, 1, 1, 0);

      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK_1Hz);

      foreach (tbl[i]) begin
         drive(tbl[i].rst_n, tbl[i].clr, tbl[i].ld, tbl[i].pause, tbl[i].start, tbl[i].msel,
               tbl[i].pm, tbl[i].pl);
         tick();
         check(tbl[i].name, tbl[i].e_msb, tbl[i].e_lsb, tbl[i].e_stop, tbl[i].e_mode, tbl[i].e_done);
      end

      // Mode B countdown from 01:01 through the minute borrow to 00:00
      drive(1, 1, 0, 0, 0, 1, 0, 0); tick(); check("cd_clear", 0, 0, 1, 1, 0);
      drive(1, 0, 1, 0, 0, 1, 1, 1); tick(); check("cd_load", 1, 1, 1, 1, 0);
      drive(1, 0, 0, 0, 1, 1, 0, 0); tick(); check("cd_start", 1, 1, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 1, 0, 0);
      for (int k = 1; k <= 61; k++) begin
         tick();
         t = 61 - k;
         check("cd_step", t / 60, t % 60, k == 61, 1'b1, k == 61);
      end
      tick(); check("cd_hold", 0, 0, 1, 1, 0);

      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 63) != 0,
               $urandom_range(0, 39) == 0,
               $urandom_range(0, 11) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 2) == 0,
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 1)),
               int'($urandom_range(0, 99)));
         tick();
         check("random", m_t / 60, m_t % 60, m_st != M_RUN, m_mode, m_done);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
